// File: rtl/pulse_scheduler_mc.sv
// pulse_scheduler_mc
//   Multi-channel timed pulse scheduler. Each channel owns a FIFO of
//   {tstart, tlen, param} descriptors and a small FSM that waits for the
//   shared timer to reach the head's start time, issues the pulse as a
//   valid/ready command, then holds busy for tlen cycles.
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   desc_*           : descriptor write port (valid/ready), desc_ch selects channel
//   run_en           : timer counts while high
//   timer_clear      : synchronous timer zero (wins over run_en)
//   timer            : free-running timestamp
//   cmd_valid/ready  : per-channel command handshake, cmd_param/cmd_tlen sliced per channel
//   busy             : channel is playing a pulse
//   full, empty      : per-channel FIFO status
//   late_err         : sticky, a pulse was issued after its start time
//   bad_ch_err       : sticky, a descriptor named a non-existent channel
module pulse_scheduler_mc #(
    parameter int NUM_CH  = 4,
    parameter int DEPTH   = 8,
    parameter int TIME_W  = 32,
    parameter int LEN_W   = 16,
    parameter int PARAM_W = 64,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      desc_valid,
    output logic                      desc_ready,
    input  logic [CH_W-1:0]           desc_ch,
    input  logic [TIME_W-1:0]         desc_tstart,
    input  logic [LEN_W-1:0]          desc_tlen,
    input  logic [PARAM_W-1:0]        desc_param,
    input  logic                      run_en,
    input  logic                      timer_clear,
    output logic [TIME_W-1:0]         timer,
    output logic [NUM_CH-1:0]         cmd_valid,
    input  logic [NUM_CH-1:0]         cmd_ready,
    output logic [NUM_CH*PARAM_W-1:0] cmd_param,
    output logic [NUM_CH*LEN_W-1:0]   cmd_tlen,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         full,
    output logic [NUM_CH-1:0]         empty,
    output logic [NUM_CH-1:0]         late_err,
    output logic                      bad_ch_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [TIME_W-1:0]  tstart;
        logic [LEN_W-1:0]   tlen;
        logic [PARAM_W-1:0] param;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_PLAY} state_t;

    logic   ch_in_range;
    entry_t new_entry;

    assign ch_in_range = (int'(desc_ch) < NUM_CH);
    assign new_entry   = '{tstart: desc_tstart, tlen: desc_tlen, param: desc_param};

    // Out-of-range channels are always "ready" so the writer is never stalled;
    // the descriptor is simply discarded and flagged.
    always_comb begin
        desc_ready = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(desc_ch) == c) desc_ready = !full[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_ch_err <= 1'b0;
        end else if (desc_valid && !ch_in_range) begin
            bad_ch_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (timer_clear) begin
            timer <= '0;
        end else if (run_en) begin
            timer <= timer + TIME_W'(1);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        entry_t             mem [DEPTH];
        entry_t             head;
        logic [PTR_W-1:0]   wr_ptr;
        logic [PTR_W-1:0]   rd_ptr;
        logic [CNT_W-1:0]   count;
        logic               wr_en;
        logic               pop;
        state_t             state;
        logic [LEN_W-1:0]   play_cnt;
        logic [LEN_W-1:0]   tlen_q;
        logic [PARAM_W-1:0] param_q;
        logic               valid_q;
        logic               busy_q;
        logic               late_q;

        // Write gating looks only at the current count, so a full FIFO
        // refuses a write even when it pops on the same edge.
        assign wr_en    = desc_valid && ch_in_range && (int'(desc_ch) == c)
                          && (count != CNT_W'(DEPTH));
        assign head     = mem[rd_ptr];
        assign pop      = (state == S_WAIT) && run_en && (timer >= head.tstart);
        assign full[c]  = (count == CNT_W'(DEPTH));
        assign empty[c] = (count == '0);

        assign cmd_valid[c]                       = valid_q;
        assign busy[c]                            = busy_q;
        assign late_err[c]                        = late_q;
        assign cmd_param[c*PARAM_W +: PARAM_W]    = param_q;
        assign cmd_tlen[c*LEN_W +: LEN_W]         = tlen_q;

        always_ff @(posedge clk) begin
            if (wr_en) mem[wr_ptr] <= new_entry;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(wr_en) - CNT_W'(pop);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= S_IDLE;
                valid_q  <= 1'b0;
                busy_q   <= 1'b0;
                late_q   <= 1'b0;
                param_q  <= '0;
                tlen_q   <= '0;
                play_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!empty[c]) state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (pop) begin
                            state   <= S_ISSUE;
                            valid_q <= 1'b1;
                            param_q <= head.param;
                            tlen_q  <= head.tlen;
                            if (timer > head.tstart) late_q <= 1'b1;
                        end
                    end
                    S_ISSUE: begin
                        if (cmd_ready[c]) begin
                            valid_q <= 1'b0;
                            if (tlen_q == '0) begin
                                state <= S_IDLE;
                            end else begin
                                state    <= S_PLAY;
                                busy_q   <= 1'b1;
                                play_cnt <= tlen_q;
                            end
                        end
                    end
                    S_PLAY: begin
                        // play_cnt counts the busy cycles still to show,
                        // including the current one.
                        if (play_cnt == LEN_W'(1)) begin
                            busy_q <= 1'b0;
                            state  <= empty[c] ? S_IDLE : S_WAIT;
                        end else begin
                            play_cnt <= play_cnt - LEN_W'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_scheduler_mc.sv
module tb_pulse_scheduler_mc;

    localparam int NCH = 3;
    localparam int DEP = 4;
    localparam int TW  = 16;
    localparam int LW  = 8;
    localparam int PW  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              desc_valid = 1'b0;
    logic              desc_ready;
    logic [1:0]        desc_ch = '0;
    logic [TW-1:0]     desc_tstart = '0;
    logic [LW-1:0]     desc_tlen = '0;
    logic [PW-1:0]     desc_param = '0;
    logic              run_en = 1'b0;
    logic              timer_clear = 1'b0;
    logic [TW-1:0]     timer;
    logic [NCH-1:0]    cmd_valid;
    logic [NCH-1:0]    cmd_ready = '0;
    logic [NCH*PW-1:0] cmd_param;
    logic [NCH*LW-1:0] cmd_tlen;
    logic [NCH-1:0]    busy, full, empty, late_err;
    logic              bad_ch_err;

    pulse_scheduler_mc #(
        .NUM_CH(NCH), .DEPTH(DEP), .TIME_W(TW), .LEN_W(LW), .PARAM_W(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_ch(desc_ch),
        .desc_tstart(desc_tstart), .desc_tlen(desc_tlen), .desc_param(desc_param),
        .run_en(run_en), .timer_clear(timer_clear), .timer(timer),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_param(cmd_param), .cmd_tlen(cmd_tlen),
        .busy(busy), .full(full), .empty(empty), .late_err(late_err),
        .bad_ch_err(bad_ch_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive right after the rising edge; a descriptor is only
    // offered for the cycle in which it is driven.
    task automatic step();
        @(posedge clk);
        #1;
        desc_valid = 1'b0;
    endtask

    task automatic wr(input int ch, input int ts, input int tl, input int prm);
        step();
        desc_valid  = 1'b1;
        desc_ch     = 2'(ch);
        desc_tstart = TW'(ts);
        desc_tlen   = LW'(tl);
        desc_param  = PW'(prm);
        @(negedge clk);
    endtask

    logic mon_on = 1'b0;

    task automatic reset_dut();
        mon_on      = 1'b0;
        desc_valid  = 1'b0;
        desc_ch     = '0;
        run_en      = 1'b0;
        timer_clear = 1'b0;
        cmd_ready   = '0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed observation helpers ----------------
    int            iss_n [NCH];
    int            busy_n[NCH];
    logic [TW-1:0] iss_t [NCH][4];
    logic [TW-1:0] busy_t0[NCH];
    logic [PW-1:0] iss_p [NCH];
    logic [LW-1:0] iss_l [NCH];
    logic [NCH-1:0] ocv, ohs;

    task automatic obs_clear();
        for (int c = 0; c < NCH; c++) begin
            iss_n[c] = 0; busy_n[c] = 0; busy_t0[c] = '0;
        end
        ocv = '0; ohs = '0;
    endtask

    task automatic run_obs(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if (cmd_valid[c] && (!ocv[c] || ohs[c])) begin
                    if (iss_n[c] < 4) iss_t[c][iss_n[c]] = timer;
                    iss_p[c] = cmd_param[c*PW +: PW];
                    iss_l[c] = cmd_tlen[c*LW +: LW];
                    iss_n[c]++;
                end
                if (busy[c]) begin
                    if (busy_n[c] == 0) busy_t0[c] = timer;
                    busy_n[c]++;
                end
                ocv[c] = cmd_valid[c];
                ohs[c] = cmd_valid[c] & cmd_ready[c];
            end
        end
    endtask

    // ---------------- reference model for random traffic ----------------
    typedef struct packed {
        logic [TW-1:0] tstart;
        logic [LW-1:0] tlen;
        logic [PW-1:0] param;
    } ment_t;

    ment_t          mq [NCH][$];
    logic [NCH-1:0] cv_prev, hs_prev;
    logic [TW-1:0]  tm, tm_prev;
    logic           run_prev;
    logic [PW-1:0]  hold_param[NCH];
    logic [LW-1:0]  hold_tlen [NCH];
    int             play_left [NCH];
    logic [NCH-1:0] late_m;
    logic           bad_m;
    ment_t          ent;
    logic           exp_rdy;

    always @(negedge clk) begin
        if (mon_on) begin
            for (int c = 0; c < NCH; c++) begin
                if (cmd_valid[c] && (!cv_prev[c] || hs_prev[c])) begin
                    if (mq[c].size() == 0) begin
                        chk("rnd_unexpected_issue", cmd_valid[c], 0);
                    end else begin
                        ent = mq[c].pop_front();
                        chk("rnd_issue_param", cmd_param[c*PW +: PW], ent.param);
                        chk("rnd_issue_tlen", cmd_tlen[c*LW +: LW], ent.tlen);
                        chk("rnd_issue_due", (run_prev && (tm_prev >= ent.tstart)), 1);
                        if (tm_prev > ent.tstart) late_m[c] = 1'b1;
                        hold_param[c] = ent.param;
                        hold_tlen[c]  = ent.tlen;
                    end
                end else if (cv_prev[c] && !hs_prev[c]) begin
                    chk("rnd_hold_valid", cmd_valid[c], 1);
                    chk("rnd_hold_param", cmd_param[c*PW +: PW], hold_param[c]);
                end
                chk("rnd_busy", busy[c], (play_left[c] > 0));
                if (play_left[c] > 0) play_left[c]--;
                if (cmd_valid[c] && cmd_ready[c]) play_left[c] = int'(hold_tlen[c]);
                chk("rnd_late", late_err[c], late_m[c]);
                chk("rnd_empty", empty[c], (mq[c].size() == 0));
                chk("rnd_full", full[c], (mq[c].size() == DEP));
            end
            exp_rdy = (int'(desc_ch) < NCH) ? (mq[desc_ch].size() < DEP) : 1'b1;
            chk("rnd_desc_ready", desc_ready, exp_rdy);
            chk("rnd_bad_ch", bad_ch_err, bad_m);
            chk("rnd_timer", timer, tm);
            if (desc_valid) begin
                if (int'(desc_ch) >= NCH) bad_m = 1'b1;
                else if (mq[desc_ch].size() < DEP)
                    mq[desc_ch].push_back('{tstart: desc_tstart, tlen: desc_tlen, param: desc_param});
            end
            tm_prev  = tm;
            run_prev = run_en;
            if (timer_clear) tm = '0;
            else if (run_en) tm = tm + 1'b1;
            cv_prev = cmd_valid;
            hs_prev = cmd_valid & cmd_ready;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic           v;
        logic [1:0]     ch;
        logic           run;
        logic           clr;
        logic           exp_rdy;
        logic [NCH-1:0] exp_full;
        logic [NCH-1:0] exp_empty;
        logic [TW-1:0]  exp_t;
    } vec_t;

    vec_t vt[12];

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;

        vt[0]  = '{1, 2'd1, 0, 0, 1, 3'b000, 3'b111, 16'd0};
        vt[1]  = '{1, 2'd1, 0, 0, 1, 3'b000, 3'b101, 16'd0};
        vt[2]  = '{1, 2'd1, 0, 0, 1, 3'b000, 3'b101, 16'd0};
        vt[3]  = '{1, 2'd1, 0, 0, 1, 3'b000, 3'b101, 16'd0};
        vt[4]  = '{1, 2'd1, 0, 0, 0, 3'b010, 3'b101, 16'd0};
        vt[5]  = '{1, 2'd0, 0, 0, 1, 3'b010, 3'b101, 16'd0};
        vt[6]  = '{0, 2'd0, 1, 0, 1, 3'b010, 3'b100, 16'd0};
        vt[7]  = '{0, 2'd1, 1, 0, 0, 3'b010, 3'b100, 16'd1};
        vt[8]  = '{0, 2'd3, 0, 0, 1, 3'b010, 3'b100, 16'd2};
        vt[9]  = '{0, 2'd2, 1, 1, 1, 3'b010, 3'b100, 16'd2};
        vt[10] = '{0, 2'd0, 1, 0, 1, 3'b010, 3'b100, 16'd0};
        vt[11] = '{0, 2'd0, 0, 0, 1, 3'b010, 3'b100, 16'd1};

        // reset state
        reset_dut();
        chk("rst_timer", timer, 0);
        chk("rst_empty", empty, 3'b111);
        chk("rst_full", full, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_late", late_err, 0);
        chk("rst_bad_ch", bad_ch_err, 0);
        chk("rst_cmd_param", cmd_param, 0);
        chk("rst_cmd_tlen", cmd_tlen, 0);

        // table: FIFO fill / full refusal on ch1, ch0 still accepted, timer control
        for (int i = 0; i < 12; i++) begin
            step();
            desc_valid  = vt[i].v;
            desc_ch     = vt[i].ch;
            desc_tstart = 16'd1000;
            desc_tlen   = 8'd1;
            desc_param  = PW'(i);
            run_en      = vt[i].run;
            timer_clear = vt[i].clr;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), desc_ready, vt[i].exp_rdy);
            chk($sformatf("vec%0d_full", i), full, vt[i].exp_full);
            chk($sformatf("vec%0d_empty", i), empty, vt[i].exp_empty);
            chk($sformatf("vec%0d_timer", i), timer, vt[i].exp_t);
        end

        // on-time pulse, tlen=3
        reset_dut();
        cmd_ready = '1;
        obs_clear();
        wr(0, 10, 3, 'hA5A5);
        run_en = 1'b1;
        run_obs(20);
        chk("A_issue_count", iss_n[0], 1);
        chk("A_issue_time", iss_t[0][0], 11);
        chk("A_param", iss_p[0], 16'hA5A5);
        chk("A_tlen", iss_l[0], 3);
        chk("A_busy_cycles", busy_n[0], 3);
        chk("A_busy_start", busy_t0[0], 12);
        chk("A_late", late_err[0], 0);

        // late pulse, then a zero-length pulse
        reset_dut();
        cmd_ready = '1;
        run_en = 1'b1;
        for (int i = 0; i < 19; i++) step();
        obs_clear();
        wr(0, 5, 2, 'h5555);
        chk("B_timer_at_write", timer, 20);
        run_obs(8);
        chk("B_issue_time", iss_t[0][0], 23);
        chk("B_late", late_err[0], 1);
        chk("B_busy_cycles", busy_n[0], 2);
        chk("B_busy_start", busy_t0[0], 24);
        obs_clear();
        wr(0, 21, 0, 'h0BEE);
        run_obs(8);
        chk("B0_issue_count", iss_n[0], 1);
        chk("B0_issue_time", iss_t[0][0], 32);
        chk("B0_tlen", iss_l[0], 0);
        chk("B0_param", iss_p[0], 16'h0BEE);
        chk("B0_no_busy", busy_n[0], 0);
        chk("B0_valid_low", cmd_valid[0], 0);
        chk("B0_empty", empty[0], 1);

        // back-to-back on ch0 while ch1 runs in parallel
        reset_dut();
        cmd_ready = '1;
        obs_clear();
        wr(0, 10, 8, 'h1111);
        run_en = 1'b1;
        wr(0, 12, 1, 'h2222);
        wr(1, 12, 5, 'h3333);
        run_obs(25);
        chk("C_ch0_issues", iss_n[0], 2);
        chk("C_ch0_first", iss_t[0][0], 11);
        chk("C_ch0_second", iss_t[0][1], 21);
        chk("C_ch1_issues", iss_n[1], 1);
        chk("C_ch1_time", iss_t[1][0], 13);
        chk("C_late", late_err, 3'b001);
        chk("C_ch0_busy", busy_n[0], 9);
        chk("C_ch1_busy", busy_n[1], 5);
        chk("C_ch1_busy_start", busy_t0[1], 14);

        // back-pressure hold and out-of-range channel
        reset_dut();
        wr(0, 2, 1, 'h1234);
        run_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            @(negedge clk);
            if (cmd_valid[0]) ok = 1'b1;
        end
        chk("D_issue_reached", ok, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk);
            chk($sformatf("D_hold_valid%0d", i), cmd_valid[0], 1);
            chk($sformatf("D_hold_param%0d", i), cmd_param[PW-1:0], 16'h1234);
        end
        chk("D_bad_before", bad_ch_err, 0);
        wr(3, 0, 1, 'hDEAD);
        chk("D_bad_ready", desc_ready, 1);
        step();
        @(negedge clk);
        chk("D_bad_after", bad_ch_err, 1);
        chk("D_bad_dropped", empty, 3'b111);
        cmd_ready = '1;
        step();
        @(negedge clk);
        chk("D_handshake", cmd_valid[0], 0);

        // reset in the middle of a pulse with three queued
        reset_dut();
        cmd_ready = '1;
        wr(0, 0, 20, 'hAAAA);
        run_en = 1'b1;
        wr(0, 500, 1, 'h1);
        wr(0, 500, 1, 'h2);
        wr(0, 500, 1, 'h3);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step();
            @(negedge clk);
            if (busy[0]) ok = 1'b1;
        end
        chk("E_busy_reached", ok, 1);
        rst_n = 1'b0;
        #1;
        chk("E_busy", busy, 0);
        chk("E_cmd_valid", cmd_valid, 0);
        chk("E_empty", empty, 3'b111);
        chk("E_full", full, 0);
        chk("E_timer", timer, 0);
        chk("E_late", late_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_en = 1'b0;
        obs_clear();
        run_obs(10);
        chk("E_no_issue", iss_n[0], 0);
        chk("E_no_busy", busy_n[0], 0);
        chk("E_still_empty", empty, 3'b111);

        // randomized traffic against the queue model
        reset_dut();
        for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            play_left[c] = 0;
            hold_param[c] = '0;
            hold_tlen[c] = '0;
        end
        cv_prev = '0; hs_prev = '0; late_m = '0; bad_m = 1'b0;
        tm = '0; tm_prev = '0; run_prev = 1'b0;
        step();
        mon_on = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            desc_valid  = ($urandom_range(0, 9) < 4);
            desc_ch     = 2'($urandom_range(0, 3));
            desc_tstart = timer + TW'($urandom_range(0, 40));
            desc_tlen   = LW'($urandom_range(0, 5));
            desc_param  = PW'($urandom);
            run_en      = ($urandom_range(0, 9) != 0);
            timer_clear = ($urandom_range(0, 299) == 0);
            cmd_ready   = NCH'($urandom);
            step();
        end
        mon_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
